// File: rtl/buffer_r_pkg.sv
// Shared constants for the CoreUART receive-side host buffer: register map,
// status bit positions and the per-entry layout {fe, pe, data}.
package buffer_r_pkg;

  localparam logic [1:0] ADDR_DATA       = 2'b00;
  localparam logic [1:0] ADDR_STATUS     = 2'b01;
  localparam logic [1:0] ADDR_COUNT      = 2'b10;
  localparam logic [1:0] ADDR_STATUS_CLR = 2'b11;

  localparam int ST_RXRDY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_PE    = 2;
  localparam int ST_FE    = 3;
  localparam int ST_OVR   = 4;

  // Error flags sit directly above the data byte in each entry.
  localparam int FLAG_W  = 2;
  localparam int ENT_PE  = 0;
  localparam int ENT_FE  = 1;

endpackage

// File: rtl/buffer_r_fifo.sv
// Generic count-based FIFO: a push into a full FIFO is accepted only when a
// pop happens in the same cycle; otherwise it is dropped and flagged.
module buffer_r_fifo
  import buffer_r_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int EW    = 10
) (
  input  logic          rClk,
  input  logic          rRst,
  input  logic          push,
  input  logic          pop,
  input  logic [EW-1:0] wdata,
  output logic [EW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic          drop,
  output logic [AW:0]   count
);

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] rptr_p1, wptr_p1;
  logic [AW:0]   cnt_p1;
  logic          pop_ok, push_ok;

  assign empty   = (cnt_p1 == '0);
  assign full    = (cnt_p1 == (AW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && !push_ok;
  assign rdata   = mem[rptr_p1];
  assign count   = cnt_p1;

  // Pointer/count stage; pointers wrap naturally because DEPTH == 2**AW.
  always_ff @(posedge rClk) begin
    if (!rRst) begin
      rptr_p1 <= '0;
      wptr_p1 <= '0;
      cnt_p1  <= '0;
    end else begin
      if (push_ok) wptr_p1 <= wptr_p1 + 1'b1;
      if (pop_ok)  rptr_p1 <= rptr_p1 + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt_p1 <= cnt_p1 + 1'b1;
        2'b01:   cnt_p1 <= cnt_p1 - 1'b1;
        default: cnt_p1 <= cnt_p1;
      endcase
    end
  end

  always_ff @(posedge rClk) begin
    if (rRst && push_ok) mem[wptr_p1] <= wdata;
  end

endmodule

// File: rtl/buffer_r.sv
// Receive-side host buffer: shifter pushes bytes with error flags, host reads
// data/status/count through a 2-bit address with a registered 1-cycle result.
module buffer_r
  import buffer_r_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int DW    = 8
) (
  input  logic          rClk,
  input  logic          rRst,
  input  logic          rxWrEn,
  input  logic [DW-1:0] rxData,
  input  logic          rxParityErr,
  input  logic          rxFramingErr,
  input  logic          rRD,
  input  logic [1:0]    rpaddr,
  output logic [DW-1:0] rdataOut,
  output logic          rEMPTY,
  output logic          rFULL,
  output logic          rxrdy,
  output logic          rOVERRUN
);

  localparam int EW = DW + FLAG_W;

  logic [EW-1:0] ent_rd;
  logic [AW:0]   count;
  logic          drop, rd_data, rd_clr;
  logic          overrun_p1, last_pe_p1, last_fe_p1;
  logic [DW-1:0] status;

  function automatic logic [DW-1:0] pack_status(input logic ovr, input logic fe,
                                                 input logic pe, input logic full,
                                                 input logic rdy);
    logic [DW-1:0] s;
    s           = '0;
    s[ST_OVR]   = ovr;
    s[ST_FE]    = fe;
    s[ST_PE]    = pe;
    s[ST_FULL]  = full;
    s[ST_RXRDY] = rdy;
    return s;
  endfunction

  assign rd_data = rRD && (rpaddr == ADDR_DATA);
  assign rd_clr  = rRD && (rpaddr == ADDR_STATUS_CLR);

  buffer_r_fifo #(.DEPTH(DEPTH), .AW(AW), .EW(EW)) u_fifo (
    .rClk  (rClk),
    .rRst  (rRst),
    .push  (rxWrEn),
    .pop   (rd_data),
    .wdata ({rxFramingErr, rxParityErr, rxData}),
    .rdata (ent_rd),
    .full  (rFULL),
    .empty (rEMPTY),
    .drop  (drop),
    .count (count)
  );

  assign rxrdy    = !rEMPTY;
  assign rOVERRUN = overrun_p1;
  assign status   = pack_status(overrun_p1, last_fe_p1, last_pe_p1, rFULL, !rEMPTY);

  // Host read stage: decode address into rdataOut and update sticky flags.
  always_ff @(posedge rClk) begin
    if (!rRst) begin
      rdataOut   <= '0;
      overrun_p1 <= 1'b0;
      last_pe_p1 <= 1'b0;
      last_fe_p1 <= 1'b0;
    end else begin
      if (rRD) begin
        case (rpaddr)
          ADDR_DATA: begin
            if (!rEMPTY) begin
              rdataOut   <= ent_rd[DW-1:0];
              last_pe_p1 <= ent_rd[DW+ENT_PE];
              last_fe_p1 <= ent_rd[DW+ENT_FE];
            end else begin
              rdataOut <= '0;
            end
          end
          ADDR_STATUS: rdataOut <= status;
          ADDR_COUNT:  rdataOut <= DW'(count);
          default: begin
            rdataOut   <= status;
            last_pe_p1 <= 1'b0;
            last_fe_p1 <= 1'b0;
          end
        endcase
      end
      // A drop in the same cycle as a clear leaves overrun set.
      if (drop)        overrun_p1 <= 1'b1;
      else if (rd_clr) overrun_p1 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_buffer_r.sv
// Directed bench for buffer_r: hand-computed expectations for reset, FIFO
// order, error flags, overrun, full push+pop, empty push+pop and reset mid-stream.
module tb_buffer_r;

  logic       rClk = 1'b0;
  logic       rRst;
  logic       rxWrEn;
  logic [7:0] rxData;
  logic       rxParityErr;
  logic       rxFramingErr;
  logic       rRD;
  logic [1:0] rpaddr;
  logic [7:0] rdataOut;
  logic       rEMPTY, rFULL, rxrdy, rOVERRUN;

  int total = 0;
  int bad   = 0;

  buffer_r #(.DEPTH(4), .AW(2), .DW(8)) dut (
    .rClk        (rClk),
    .rRst        (rRst),
    .rxWrEn      (rxWrEn),
    .rxData      (rxData),
    .rxParityErr (rxParityErr),
    .rxFramingErr(rxFramingErr),
    .rRD         (rRD),
    .rpaddr      (rpaddr),
    .rdataOut    (rdataOut),
    .rEMPTY      (rEMPTY),
    .rFULL       (rFULL),
    .rxrdy       (rxrdy),
    .rOVERRUN    (rOVERRUN)
  );

  always #5 rClk = ~rClk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge rClk);
    #1;
    rxWrEn = 1'b0;
    rRD    = 1'b0;
    rxParityErr  = 1'b0;
    rxFramingErr = 1'b0;
  endtask

  task automatic push(input logic [7:0] d, input logic pe, input logic fe);
    rxWrEn = 1'b1; rxData = d; rxParityErr = pe; rxFramingErr = fe;
    tick();
  endtask

  task automatic rd(input logic [1:0] a);
    rRD = 1'b1; rpaddr = a;
    tick();
  endtask

  initial begin
    rRst = 1'b0; rxWrEn = 1'b0; rxData = '0; rxParityErr = 1'b0;
    rxFramingErr = 1'b0; rRD = 1'b0; rpaddr = 2'b00;
    tick(); tick();
    rRst = 1'b1;
    tick();

    // reset state
    chk("rst_empty", rEMPTY, 1);
    chk("rst_full", rFULL, 0);
    chk("rst_rxrdy", rxrdy, 0);
    chk("rst_ovr", rOVERRUN, 0);
    chk("rst_data", rdataOut, 8'h00);
    rd(2'b01); chk("rst_status", rdataOut, 8'h00);
    rd(2'b10); chk("rst_count", rdataOut, 8'h00);

    // basic order
    push(8'h41, 0, 0); push(8'h42, 0, 0); push(8'h43, 0, 0);
    chk("rxrdy_3", rxrdy, 1);
    rd(2'b10); chk("count_3", rdataOut, 8'h03);
    rd(2'b00); chk("pop_41", rdataOut, 8'h41);
    rd(2'b00); chk("pop_42", rdataOut, 8'h42);
    rd(2'b00); chk("pop_43", rdataOut, 8'h43);
    chk("empty_after3", rEMPTY, 1);
    rd(2'b00); chk("pop_empty", rdataOut, 8'h00);

    // error flags
    push(8'hA5, 1, 0); push(8'h5A, 0, 1);
    rd(2'b00); chk("pop_A5", rdataOut, 8'hA5);
    rd(2'b01); chk("status_pe", rdataOut, 8'h05);
    rd(2'b00); chk("pop_5A", rdataOut, 8'h5A);
    rd(2'b01); chk("status_fe", rdataOut, 8'h08);
    rd(2'b11); chk("statclr_ret", rdataOut, 8'h08);
    rd(2'b01); chk("status_cleared", rdataOut, 8'h00);

    // overrun
    for (int i = 0; i < 4; i++) push(8'h10 + 8'(i), 0, 0);
    chk("full_4", rFULL, 1);
    chk("ovr_before", rOVERRUN, 0);
    push(8'h14, 0, 0);
    chk("ovr_set", rOVERRUN, 1);
    rd(2'b01); chk("status_ovr", rdataOut, 8'h13);
    for (int i = 0; i < 4; i++) begin
      rd(2'b00); chk("drain_ovr", rdataOut, 8'h10 + 8'(i));
    end
    chk("empty_drained", rEMPTY, 1);
    rd(2'b11); chk("statclr_ovr", rdataOut, 8'h10);
    chk("ovr_cleared", rOVERRUN, 0);

    // full with simultaneous push and pop
    for (int i = 0; i < 4; i++) push(8'h20 + 8'(i), 0, 0);
    rxWrEn = 1'b1; rxData = 8'h77; rRD = 1'b1; rpaddr = 2'b00;
    tick();
    chk("fullpp_data", rdataOut, 8'h20);
    chk("fullpp_ovr", rOVERRUN, 0);
    chk("fullpp_full", rFULL, 1);
    rd(2'b10); chk("fullpp_count", rdataOut, 8'h04);
    rd(2'b00); chk("fullpp_d1", rdataOut, 8'h21);
    rd(2'b00); chk("fullpp_d2", rdataOut, 8'h22);
    rd(2'b00); chk("fullpp_d3", rdataOut, 8'h23);
    rd(2'b00); chk("fullpp_d4", rdataOut, 8'h77);

    // empty with simultaneous push and pop: no bypass
    rxWrEn = 1'b1; rxData = 8'h99; rRD = 1'b1; rpaddr = 2'b00;
    tick();
    chk("emptypp_data", rdataOut, 8'h00);
    rd(2'b10); chk("emptypp_count", rdataOut, 8'h01);
    rd(2'b00); chk("emptypp_pop", rdataOut, 8'h99);

    // dropped push wins over a same-cycle clear
    for (int i = 0; i < 4; i++) push(8'h30 + 8'(i), 0, 0);
    rxWrEn = 1'b1; rxData = 8'h55; rRD = 1'b1; rpaddr = 2'b11;
    tick();
    chk("setwins_ret", rdataOut, 8'h03);
    chk("setwins_ovr", rOVERRUN, 1);
    rd(2'b00); chk("pe_carry_pop", rdataOut, 8'h30);

    // reset mid-stream with a DATA read pending
    push(8'h61, 1, 1); push(8'h62, 0, 0);
    rRst = 1'b0; rRD = 1'b1; rpaddr = 2'b00;
    tick();
    rRst = 1'b1;
    chk("midrst_data", rdataOut, 8'h00);
    chk("midrst_empty", rEMPTY, 1);
    chk("midrst_full", rFULL, 0);
    chk("midrst_ovr", rOVERRUN, 0);
    rd(2'b01); chk("midrst_status", rdataOut, 8'h00);
    rd(2'b10); chk("midrst_count", rdataOut, 8'h00);

    // rRD=0 holds rdataOut
    push(8'hC3, 0, 0);
    rd(2'b00); chk("hold_pop", rdataOut, 8'hC3);
    tick(); tick();
    chk("hold_value", rdataOut, 8'hC3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
